ram_copy_engine: RTL and testbench

Block-copy initiator for the synchronous dual-port RAM: on a single `start` command it copies `len` consecutive words from a source address range to a destination range by driving the RAM's read port and write port. Read-port data returns one cycle after the read is issued, and the engine pipelines reads and writes so that one word moves per cycle. Overlapping ranges are handled memmove-style by choosing the copy direction. The block sits between the control logic and the RAM instance, and the RAM's ports belong to the engine while `busy` is high.

---
 rtl/ram_copy_engine.sv | 112 +++++++++++
 tb/tb_ram_copy_engine.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// Block copy engine driving a dual-port RAM: one word per cycle, memmove-safe
// direction choice, registered-read pipeline with one-cycle FLUSH for the last write.
module ram_copy_engine #(
  parameter int ADDRESS_DEPTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_SIZE  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDRESS_SIZE-1:0] src_addr,
  input  logic [ADDRESS_SIZE-1:0] dst_addr,
  input  logic [ADDRESS_SIZE:0]   len,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_re,
  output logic [ADDRESS_SIZE-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data,
  output logic                    ram_we,
  output logic [ADDRESS_SIZE-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   ram_wr_data
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing reads, writing the previous word
  // FLUSH | writing the final word
  // DONE  | one-cycle completion pulse
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDRESS_SIZE:0]   DEPTH   = (ADDRESS_SIZE+1)'(ADDRESS_DEPTH);
  localparam logic [ADDRESS_SIZE:0]   CNT_ONE = (ADDRESS_SIZE+1)'(1);
  localparam logic [ADDRESS_SIZE-1:0] PTR_ONE = ADDRESS_SIZE'(1);

  logic [1:0]              state;
  logic [ADDRESS_SIZE-1:0] rd_ptr;
  logic [ADDRESS_SIZE-1:0] wr_ptr;
  logic [ADDRESS_SIZE:0]   cnt;
  logic                    desc;
  logic                    wr_act;

  logic [ADDRESS_SIZE:0]   len_sat;
  logic [ADDRESS_SIZE-1:0] len_low;
  logic [ADDRESS_SIZE-1:0] diff;
  logic                    start_desc;

  always_comb begin
    len_sat    = (len > DEPTH) ? DEPTH : len;
    len_low    = len_sat[ADDRESS_SIZE-1:0];
    diff       = dst_addr - src_addr;
    // copy from the top down when the destination starts inside the source window
    start_desc = (dst_addr != src_addr) && ({1'b0, diff} < len_sat);
  end

  function automatic logic [ADDRESS_SIZE-1:0] step_ptr(input logic [ADDRESS_SIZE-1:0] p,
                                                       input logic down);
    return down ? (p - PTR_ONE) : (p + PTR_ONE);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      desc   <= 1'b0;
      wr_act <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            desc   <= start_desc;
            cnt    <= len_sat;
            wr_act <= 1'b0;
            if (start_desc) begin
              rd_ptr <= src_addr + len_low - PTR_ONE;
              wr_ptr <= dst_addr + len_low - PTR_ONE;
            end else begin
              rd_ptr <= src_addr;
              wr_ptr <= dst_addr;
            end
            state <= (len_sat == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          rd_ptr <= step_ptr(rd_ptr, desc);
          cnt    <= cnt - CNT_ONE;
          wr_act <= 1'b1;
          if (wr_act) wr_ptr <= step_ptr(wr_ptr, desc);
          if (cnt == CNT_ONE) state <= S_FLUSH;
        end
        S_FLUSH: begin
          wr_ptr <= step_ptr(wr_ptr, desc);
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state == S_RUN) || (state == S_FLUSH);
  assign done        = (state == S_DONE);
  assign ram_re      = (state == S_RUN);
  assign ram_we      = ((state == S_RUN) && wr_act) || (state == S_FLUSH);
  assign ram_rd_addr = rd_ptr;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = ram_rd_data;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural registered-read RAM.
module tb_ram_copy_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] src_addr, dst_addr;
  logic [4:0] len;
  logic       busy, done, ram_re, ram_we;
  logic [3:0] ram_rd_addr, ram_wr_addr;
  logic [7:0] ram_rd_data, ram_wr_data;

  logic       ld_en;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] mem [16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_copy_engine #(.ADDRESS_DEPTH(16), .DATA_WIDTH(8), .ADDRESS_SIZE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .ram_re(ram_re), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data)
  );

  // read returns old data when the same address is written in the same cycle
  always @(posedge clk) begin
    if (ram_re) ram_rd_data <= mem[ram_rd_addr];
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 4'(i); ld_data = 8'(i + 8'h10);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Starts a copy and checks every cycle against hand-derived rd0/wr0/step,
  // then the final memory against a memmove of the snapshot.
  task automatic run_copy(input string name, input int s, input int d, input int l,
                          input int rd0, input int wr0, input int step, input bit poke);
    int eff, dn;
    logic [7:0] old_m [16];
    logic [7:0] exp_m [16];
    eff = (l > 16) ? 16 : l;
    for (int i = 0; i < 16; i++) old_m[i] = mem[i];
    exp_m = old_m;
    for (int i = 0; i < eff; i++) exp_m[(d + i) % 16] = old_m[(s + i) % 16];
    dn = (eff == 0) ? 1 : eff + 2;
    @(negedge clk);
    start = 1'b1; src_addr = 4'(s); dst_addr = 4'(d); len = 5'(l);
    for (int c = 1; c <= dn + 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      chk($sformatf("%s c%0d re", name, c), int'(ram_re), int'(c <= eff));
      chk($sformatf("%s c%0d we", name, c), int'(ram_we), int'(c >= 2 && c <= eff + 1));
      chk($sformatf("%s c%0d busy", name, c), int'(busy), int'(eff > 0 && c <= eff + 1));
      chk($sformatf("%s c%0d done", name, c), int'(done), int'(c == dn));
      if (c <= eff)
        chk($sformatf("%s c%0d rd_addr", name, c), int'(ram_rd_addr), (rd0 + step * (c - 1)) & 15);
      if (c >= 2 && c <= eff + 1)
        chk($sformatf("%s c%0d wr_addr", name, c), int'(ram_wr_addr), (wr0 + step * (c - 2)) & 15);
      if (poke) begin
        if (c == 2 || c == dn) begin
          start = 1'b1; src_addr = 4'd1; dst_addr = 4'd12; len = 5'd3;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s mem[%0d]", name, i), int'(mem[i]), int'(exp_m[i]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #12;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst re", int'(ram_re), 0);
    chk("rst we", int'(ram_we), 0);
    chk("rst rd_addr", int'(ram_rd_addr), 0);
    chk("rst wr_addr", int'(ram_wr_addr), 0);
    @(negedge clk);
    rst = 1'b0;

    preload();
    run_copy("basic", 2, 9, 4, 2, 9, 1, 1'b0);
    chk("basic mem9", int'(mem[9]), 8'h12);
    chk("basic mem12", int'(mem[12]), 8'h15);

    preload();
    run_copy("ovl_fwd", 0, 2, 6, 5, 7, -1, 1'b0);
    chk("ovl_fwd mem2", int'(mem[2]), 8'h10);
    chk("ovl_fwd mem7", int'(mem[7]), 8'h15);
    chk("ovl_fwd mem1", int'(mem[1]), 8'h11);

    preload();
    run_copy("ovl_bwd", 4, 3, 5, 4, 3, 1, 1'b0);
    chk("ovl_bwd mem3", int'(mem[3]), 8'h14);
    chk("ovl_bwd mem7", int'(mem[7]), 8'h18);

    preload();
    run_copy("wrap", 14, 6, 4, 14, 6, 1, 1'b0);
    chk("wrap mem6", int'(mem[6]), 8'h1e);
    chk("wrap mem9", int'(mem[9]), 8'h11);

    run_copy("len0", 3, 7, 0, 0, 0, 1, 1'b0);
    preload();
    run_copy("full", 0, 0, 16, 0, 0, 1, 1'b0);
    run_copy("sat", 5, 5, 20, 5, 5, 1, 1'b0);

    preload();
    run_copy("poke", 1, 6, 5, 1, 6, 1, 1'b1);

    // asynchronous reset in cycle 3 of a len=8 copy
    preload();
    @(negedge clk);
    start = 1'b1; src_addr = 4'd0; dst_addr = 4'd8; len = 5'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", int'(busy), 0);
    chk("arst done", int'(done), 0);
    chk("arst re", int'(ram_re), 0);
    chk("arst we", int'(ram_we), 0);
    chk("arst rd_addr", int'(ram_rd_addr), 0);
    chk("arst wr_addr", int'(ram_wr_addr), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("arst hold%0d we", c), int'(ram_we), 0);
    end
    chk("arst mem8", int'(mem[8]), 8'h10);
    chk("arst mem9", int'(mem[9]), 8'h19);
    chk("arst mem10", int'(mem[10]), 8'h1a);
    rst = 1'b0;
    run_copy("after_rst", 0, 8, 8, 0, 8, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
